// File: rtl/xz_scrub_fifo.sv
// Capture stage for 4-state gate outputs: scrubs x/z bits to 0, records a per-bit mask,
// and buffers word+mask in a first-word-fall-through FIFO. Define XZ_SCRUB_STATS_EN for xz_count.

module xz_scrub_bit (
    input  logic d,
    output bit   q,
    output bit   m
);
    // Case-inequality against both known levels catches x and z alike.
    always_comb begin
        m = (d !== 1'b0) && (d !== 1'b1);
        q = (d === 1'b1);
    end
endmodule

module xz_scrub_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output bit               in_ready,
    input  logic [WIDTH-1:0] in_data,
    output bit               out_valid,
    input  logic             out_ready,
    output bit   [WIDTH-1:0] out_data,
    output bit   [WIDTH-1:0] out_xz_mask,
`ifdef XZ_SCRUB_STATS_EN
    output bit   [CNT_W-1:0] xz_count,
`endif
    output bit               xz_seen
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        bit [WIDTH-1:0] mask;
        bit [WIDTH-1:0] data;
    } entry_t;

    entry_t         mem [DEPTH];
    bit [PW-1:0]    wr_ptr, rd_ptr;
    bit [CW-1:0]    cnt;
    bit [WIDTH-1:0] scr_data, scr_mask;
    bit             push, pop;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            xz_scrub_bit u_bit (
                .d (in_data[g]),
                .q (scr_data[g]),
                .m (scr_mask[g])
            );
        end
    endgenerate

    // Flags come from cnt only, so out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready    = (cnt != CW'(DEPTH));
        out_valid   = (cnt != '0);
        push        = (in_valid === 1'b1) && in_ready;
        pop         = out_valid && (out_ready === 1'b1);
        out_data    = out_valid ? mem[rd_ptr].data : '0;
        out_xz_mask = out_valid ? mem[rd_ptr].mask : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= '{mask: scr_mask, data: scr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            xz_seen <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (push && (scr_mask != '0))
                xz_seen <= 1'b1;
        end
    end

`ifdef XZ_SCRUB_STATS_EN
    localparam int PCW = $clog2(WIDTH + 1);
    // Sum is wide enough for either operand plus a carry, so saturation is exact.
    localparam int SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
    localparam bit [SW-1:0] CNT_MAX = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    bit [PCW-1:0] pc;
    bit [SW-1:0]  sum;

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++)
            pc = pc + PCW'(scr_mask[i]);
        sum = SW'(xz_count) + SW'(pc);
    end

    always_ff @(posedge clk) begin
        if (rst)
            xz_count <= '0;
        else if (push)
            xz_count <= (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
`endif

endmodule

// File: tb/tb_xz_scrub_fifo.sv
// Randomized bench for xz_scrub_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.

module tb_xz_scrub_fifo;
    localparam int W     = 6;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [W-1:0] out_xz_mask;
`ifdef XZ_SCRUB_STATS_EN
    logic [CNT_W-1:0] xz_count;
`endif
    logic         xz_seen;

    xz_scrub_fifo #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_xz_mask (out_xz_mask),
`ifdef XZ_SCRUB_STATS_EN
        .xz_count    (xz_count),
`endif
        .xz_seen     (xz_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] m;
    } ent_t;

    ent_t q[$];
    bit   m_seen = 1'b0;
    int   m_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word is a list of 4-state bits; unknown bits become 0 and are flagged.
    function automatic ent_t scrub(input logic [W-1:0] v);
        ent_t e;
        for (int i = 0; i < W; i++) begin
            e.m[i] = $isunknown(v[i]);
            e.d[i] = (v[i] === 1'b1) ? 1'b1 : 1'b0;
        end
        return e;
    endfunction

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i] === 1'b1) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            q.delete();
            m_seen  = 1'b0;
            m_count = 0;
        end else begin
            bit   do_push, do_pop;
            ent_t e;
            do_push = (in_valid === 1'b1) && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && (out_ready === 1'b1);
            e = scrub(in_data);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(e);
                if (e.m != '0) m_seen = 1'b1;
                m_count = m_count + ones(e.m);
                if (m_count > (2**CNT_W - 1)) m_count = 2**CNT_W - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", in_ready, q.size() != DEPTH);
            check("out_valid", out_valid, q.size() != 0);
            check("out_data", out_data, (q.size() != 0) ? q[0].d : '0);
            check("out_xz_mask", out_xz_mask, (q.size() != 0) ? q[0].m : '0);
            check("xz_seen", xz_seen, m_seen);
`ifdef XZ_SCRUB_STATS_EN
            check("xz_count", xz_count, m_count);
`endif
        end
    end

    task automatic cyc(input logic iv, input logic [W-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rand_bit4();
        case ($urandom_range(0, 7))
            0, 1, 2: return 1'b0;
            3, 4, 5: return 1'b1;
            6:       return 1'bx;
            default: return 1'bz;
        endcase
    endfunction

    logic [W-1:0] stim;
    logic         hs;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cyc(1'b0, '0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, '0, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_xz_seen", xz_seen, 1'b0);
`ifdef XZ_SCRUB_STATS_EN
        check("rst_xz_count", xz_count, '0);
`endif
        rst = 1'b0;

        // Scrub mapping
        stim = 6'b1x0z10;
        cyc(1'b1, stim, 1'b0);
        check("scrub_valid", out_valid, 1'b1);
        if ($isunknown(stim)) begin
            check("scrub_data", out_data, 6'b100010);
            check("scrub_mask", out_xz_mask, 6'b010100);
            check("scrub_seen", xz_seen, 1'b1);
`ifdef XZ_SCRUB_STATS_EN
            check("scrub_count", xz_count, 2);
`endif
        end
        cyc(1'b0, '0, 1'b1);

        // Fill and block
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, W'(i), 1'b0);
            if (i == 4) check("full_after4", in_ready, 1'b0);
        end
        check("full_after5", in_ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check("pop_order", out_data, W'(i));
            cyc(1'b0, '0, 1'b1);
        end
        check("drained", out_valid, 1'b0);

        // Pop at full, then stream
        for (int i = 0; i < 4; i++) cyc(1'b1, W'(8 + i), 1'b0);
        cyc(1'b1, 6'h10, 1'b1);
        check("ready_after_pop", in_ready, 1'b1);
        check("head_after_pop", out_data, 6'h09);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, W'(32 + i), 1'b1);
            check("stream_ready", in_ready, 1'b1);
            check("stream_valid", out_valid, 1'b1);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);

        // X/Z on handshake
        hs = 1'bx;
        cyc(hs, 6'h3F, 1'b0);
        if ($isunknown(hs)) check("x_valid_nopush", out_valid, 1'b0);
        cyc(1'b1, 6'h15, 1'b0);
        hs = 1'bz;
        cyc(1'b0, '0, hs);
        if ($isunknown(hs)) check("z_ready_nopop", out_data, 6'h15);
        cyc(1'b0, '0, 1'b1);

        // Saturation: three all-z words
        stim = 'z;
        for (int i = 0; i < 3; i++) cyc(1'b1, stim, 1'b1);
`ifdef XZ_SCRUB_STATS_EN
        if ($isunknown(stim)) check("sat_count", xz_count, 7);
`endif
        cyc(1'b0, '0, 1'b1);

        // Reset with entries queued
        cyc(1'b1, 6'h2A, 1'b0);
        cyc(1'b1, 6'h15, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 6'h3C, 1'b1);
        rst = 1'b0;
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_data", out_data, '0);
        check("rst_mid_ready", in_ready, 1'b1);
        check("rst_mid_seen", xz_seen, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            logic iv, ordy;
            for (int b = 0; b < W; b++)
                stim[b] = ($urandom_range(0, 3) == 0) ? rand_bit4() : 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       iv = 1'bx;
                1:       iv = 1'bz;
                default: iv = ($urandom_range(0, 9) < 6);
            endcase
            case ($urandom_range(0, 15))
                0:       ordy = 1'bz;
                1:       ordy = 1'bx;
                default: ordy = ($urandom_range(0, 9) < 5);
            endcase
            rst = ($urandom_range(0, 99) == 0);
            cyc(iv, stim, ordy);
        end
        rst = 1'b0;
        cyc(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
